// File: rtl/frv_common.sv
// ============================================================================
// Module      : frv_common (package)
// Description : Shared constants for the leakage-fence block: FSM state
//               encodings, resource count and resource index map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frv_common;

    // Index of each clearable microarchitectural resource in ALCFG
    localparam int C_RES_GPR_FILE   = 0;
    localparam int C_RES_BPRED      = 1;
    localparam int C_RES_BTB        = 2;
    localparam int C_RES_FETCH_BUF  = 3;
    localparam int C_RES_DECODE_REG = 4;
    localparam int C_RES_EXEC_REG   = 5;
    localparam int C_RES_MULDIV     = 6;
    localparam int C_RES_LSU_REG    = 7;
    localparam int C_RES_LSU_BUF    = 8;
    localparam int C_RES_CSR_TMP    = 9;
    localparam int C_RES_WB_REG     = 10;
    localparam int C_RES_FWD_PATH   = 11;
    localparam int C_RES_XCRYPTO    = 12;
    localparam int C_RES_COUNT      = 13;

    localparam int C_NRES_DEFAULT   = C_RES_COUNT;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_CLEAR = 2'd1;
    localparam logic [1:0] C_ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_CLEAR = C_ST_CLEAR,
        ST_DONE  = C_ST_DONE
    } leak_state_t;

endpackage

`default_nettype wire

// File: rtl/frv_leak_pick.sv
// ============================================================================
// Module      : frv_leak_pick
// Description : Isolates the lowest set bit of a request vector as one-hot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frv_leak_pick
    import frv_common::*;
#(
    parameter int NRES = C_NRES_DEFAULT
) (
    input  logic [NRES-1:0] req_vec,
    output logic [NRES-1:0] pick_vec
);

    // Two's complement keeps only the lowest set bit; zero in gives zero out
    assign pick_vec = req_vec & (~req_vec + NRES'(1));

endmodule

`default_nettype wire

// File: rtl/frv_leak_seq.sv
// ============================================================================
// Module      : frv_leak_seq
// Description : Leakage fence sequencer; clears each ALCFG-selected resource
//               one per cycle, then acknowledges the fence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frv_leak_seq
    import frv_common::*;
#(
    parameter int               NRES                 = C_NRES_DEFAULT,
    parameter logic             XC_CLASS_LEAK_STRONG = 1'b1,
    parameter logic [NRES-1:0]  ALCFG_RESET_VALUE    = {NRES{1'b0}}
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            cfg_wen,
    input  logic [NRES-1:0] cfg_wdata,
    output logic [NRES-1:0] cfg_rdata,
    input  logic            fence_req,
    output logic            fence_ack,
    output logic            busy,
    input  logic [31:0]     leak_prng,
    output logic            prng_step,
    output logic [NRES-1:0] clr_en,
    output logic [31:0]     clr_data
);

    leak_state_t     r_state;
    leak_state_t     w_state_nxt;
    logic [NRES-1:0] r_pending;
    logic [NRES-1:0] w_pending_nxt;
    logic [NRES-1:0] r_alcfg;
    logic [NRES-1:0] w_pick;
    logic [NRES-1:0] w_remain;

    frv_leak_pick #(
        .NRES     (NRES)
    ) u_pick (
        .req_vec  (r_pending),
        .pick_vec (w_pick)
    );

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // Writable in any state; an in-flight fence works from its own snapshot
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_alcfg <= ALCFG_RESET_VALUE;
        end else if (cfg_wen) begin
            r_alcfg <= cfg_wdata;
        end
    end

    assign cfg_rdata = r_alcfg;
    assign w_remain  = r_pending & ~w_pick;

    // Outputs depend only on registered state, never directly on fence_req
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        clr_en        = '0;
        clr_data      = 32'h0;
        prng_step     = 1'b0;
        fence_ack     = 1'b0;
        busy          = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (fence_req) begin
                    w_pending_nxt = r_alcfg;
                    w_state_nxt   = (|r_alcfg) ? ST_CLEAR : ST_DONE;
                end
            end
            ST_CLEAR: begin
                clr_en        = w_pick;
                prng_step     = XC_CLASS_LEAK_STRONG;
                if (XC_CLASS_LEAK_STRONG && (|w_pick)) begin
                    clr_data = leak_prng;
                end
                w_pending_nxt = w_remain;
                w_state_nxt   = (|w_remain) ? ST_CLEAR : ST_DONE;
            end
            ST_DONE: begin
                prng_step   = 1'b1;
                fence_ack   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_frv_leak_seq.sv
// ============================================================================
// Module      : tb_frv_leak_seq
// Description : Self-checking bench for frv_leak_seq (strong and weak builds)
//               against a per-cycle expectation queue built from ALCFG.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frv_leak_seq;

    localparam int          N    = 13;
    localparam logic [N-1:0] RSTV = 13'h0011;

    logic          g_clk = 1'b0;
    logic          g_reset;
    logic          cfg_wen;
    logic [N-1:0]  cfg_wdata;
    logic          fence_req;
    logic [31:0]   leak_prng;

    logic [N-1:0]  cfg_rdata_s, cfg_rdata_w;
    logic          fence_ack_s, fence_ack_w;
    logic          busy_s, busy_w;
    logic          prng_step_s, prng_step_w;
    logic [N-1:0]  clr_en_s, clr_en_w;
    logic [31:0]   clr_data_s, clr_data_w;

    frv_leak_seq #(
        .NRES                 (N),
        .XC_CLASS_LEAK_STRONG (1'b1),
        .ALCFG_RESET_VALUE    (RSTV)
    ) u_dut_strong (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .cfg_wen   (cfg_wen),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata_s),
        .fence_req (fence_req),
        .fence_ack (fence_ack_s),
        .busy      (busy_s),
        .leak_prng (leak_prng),
        .prng_step (prng_step_s),
        .clr_en    (clr_en_s),
        .clr_data  (clr_data_s)
    );

    frv_leak_seq #(
        .NRES                 (N),
        .XC_CLASS_LEAK_STRONG (1'b0),
        .ALCFG_RESET_VALUE    (RSTV)
    ) u_dut_weak (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .cfg_wen   (cfg_wen),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata_w),
        .fence_req (fence_req),
        .fence_ack (fence_ack_w),
        .busy      (busy_w),
        .leak_prng (leak_prng),
        .prng_step (prng_step_w),
        .clr_en    (clr_en_w),
        .clr_data  (clr_data_w)
    );

    always #5 g_clk = ~g_clk;

    // One entry per busy cycle still to come; empty queue means IDLE
    typedef struct packed {
        logic [N-1:0] en;
        logic         step_s;
        logic         step_w;
        logic         ack;
    } exp_t;

    exp_t          q[$];
    logic [N-1:0]  alcfg_m;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        exp_t e;
        if (g_reset) begin
            q.delete();
            alcfg_m = RSTV;
        end else begin
            if (q.size() > 0) begin
                void'(q.pop_front());
            end else if (fence_req) begin
                for (int i = 0; i < N; i++) begin
                    if (alcfg_m[i]) begin
                        e = '0;
                        e.en[i]  = 1'b1;
                        e.step_s = 1'b1;
                        q.push_back(e);
                    end
                end
                e = '0;
                e.step_s = 1'b1;
                e.step_w = 1'b1;
                e.ack    = 1'b1;
                q.push_back(e);
            end
            if (cfg_wen) alcfg_m = cfg_wdata;
        end
    endtask

    task automatic check_outs(input string tag);
        exp_t e;
        logic idle;
        idle = (q.size() == 0);
        e    = idle ? exp_t'('0) : q[0];
        chk({tag, ".rdata_s"}, 32'(cfg_rdata_s), 32'(alcfg_m));
        chk({tag, ".rdata_w"}, 32'(cfg_rdata_w), 32'(alcfg_m));
        chk({tag, ".busy_s"},  32'(busy_s),      32'(!idle));
        chk({tag, ".busy_w"},  32'(busy_w),      32'(!idle));
        chk({tag, ".ack_s"},   32'(fence_ack_s), 32'(e.ack));
        chk({tag, ".ack_w"},   32'(fence_ack_w), 32'(e.ack));
        chk({tag, ".step_s"},  32'(prng_step_s), 32'(e.step_s));
        chk({tag, ".step_w"},  32'(prng_step_w), 32'(e.step_w));
        chk({tag, ".en_s"},    32'(clr_en_s),    32'(e.en));
        chk({tag, ".en_w"},    32'(clr_en_w),    32'(e.en));
        chk({tag, ".data_s"},  clr_data_s,       (e.en != '0) ? leak_prng : 32'h0);
        chk({tag, ".data_w"},  clr_data_w,       32'h0);
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge g_clk);
        #1;
        check_outs(tag);
        leak_prng = $urandom;
    endtask

    task automatic write_cfg(input logic [N-1:0] v);
        cfg_wen   = 1'b1;
        cfg_wdata = v;
        tick("cfg_wr");
        cfg_wen   = 1'b0;
    endtask

    // Holds fence_req until ack; latency counted from the accepting edge
    task automatic fence(input string tag, input int exp_lat);
        int cnt  = 0;
        bit seen = 0;
        fence_req = 1'b1;
        while (!seen && cnt < 40) begin
            tick(tag);
            cfg_wen = 1'b0;
            cnt++;
            if (fence_ack_s === 1'b1) seen = 1;
        end
        fence_req = 1'b0;
        chk({tag, ".latency"}, 32'(cnt), 32'(exp_lat));
        tick({tag, ".idle"});
    endtask

    initial begin
        int acks;
        g_reset   = 1'b0;
        cfg_wen   = 1'b0;
        cfg_wdata = '0;
        fence_req = 1'b0;
        leak_prng = 32'hA5A5_0001;
        alcfg_m   = RSTV;

        #1 g_reset = 1'b1;
        #1 check_outs("reset_async");
        tick("reset");
        tick("reset");
        g_reset = 1'b0;
        tick("idle");

        // Two resources, strong clear data, ack three cycles after accept
        write_cfg(13'h0005);
        fence("f0005", 3);

        // Empty config goes straight to DONE
        write_cfg(13'h0000);
        fence("f0000", 1);

        // Every resource in ascending order
        write_cfg(13'h1FFF);
        fence("f1fff", 14);

        // Write on the accept edge: snapshot keeps the old value
        write_cfg(13'h0008);
        cfg_wen   = 1'b1;
        cfg_wdata = 13'h0002;
        fence("fwr", 2);
        chk("fwr.rdata_new", 32'(cfg_rdata_s), 32'h0002);

        // Reset in the second CLEAR cycle
        write_cfg(13'h0007);
        fence_req = 1'b1;
        tick("r39a");
        tick("r39b");
        chk("r39.second_strobe", 32'(clr_en_s), 32'h0002);
        #2;
        g_reset   = 1'b1;
        fence_req = 1'b0;
        q.delete();
        alcfg_m   = RSTV;
        #1 check_outs("r39_async");
        tick("r39_hold");
        tick("r39_hold");
        g_reset = 1'b0;
        tick("r39_idle");
        fence("after_rst", 3);

        // Request held across ack, ALCFG rewritten mid-sequence
        write_cfg(13'h0003);
        fence_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                cfg_wen   = 1'b1;
                cfg_wdata = 13'h0010;
            end else begin
                cfg_wen   = 1'b0;
            end
            tick("back2back");
            if (fence_ack_s === 1'b1) acks++;
        end
        cfg_wen   = 1'b0;
        fence_req = 1'b0;
        chk("back2back.acks", 32'(acks), 32'd2);
        tick("back2back.idle");

        // Random traffic, including fence_req drops mid-sequence
        for (int i = 0; i < 400; i++) begin
            fence_req = ($urandom_range(0, 3) != 0);
            cfg_wen   = ($urandom_range(0, 7) == 0);
            cfg_wdata = N'($urandom) & N'($urandom);
            tick("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frv_leak_seq.md
FRV_LEAK_SEQ -- requirements
Module: frv_leak_seq

Interface
REQ-001 Parameter NRES, default 13, number of clearable microarchitectural resources; sets the ALCFG width.
REQ-002 Parameter XC_CLASS_LEAK_STRONG, default 1'b1; 1 = clear with PRNG data, 0 = clear with zero.
REQ-003 Parameter ALCFG_RESET_VALUE, default {NRES{1'b0}}; ALCFG reset value.
REQ-004 g_clk  in  1  single core clock; all state on rising edge.
REQ-005 g_reset  in  1  reset, asynchronous, active-high.
REQ-006 cfg_wen  in  1  write strobe for ALCFG.
REQ-007 cfg_wdata  in  NRES  ALCFG write data.
REQ-008 cfg_rdata  out  NRES  current ALCFG value.
REQ-009 fence_req  in  1  leakage fence request; held until fence_ack.
REQ-010 fence_ack  out  1  one-cycle pulse: fence sequence complete.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 leak_prng  in  32  current PRNG value.
REQ-013 prng_step  out  1  advance the PRNG this cycle; drives the PRNG's fence/step input.
REQ-014 clr_en  out  NRES  one-hot clear strobe, bit i = resource i.
REQ-015 clr_data  out  32  data written to the cleared resource.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR and DONE.
REQ-017 IDLE with fence_req=1: pending <= ALCFG; next state CLEAR if ALCFG != 0, else DONE.
REQ-018 CLEAR: clr_en SHALL be one-hot at the lowest set bit of pending, and that bit SHALL be cleared from pending the same edge.
REQ-019 CLEAR: the next state is DONE when the bit being cleared is the last set bit, else CLEAR.
REQ-020 clr_data SHALL be leak_prng when XC_CLASS_LEAK_STRONG=1, else 32'h0; clr_data is 0 whenever clr_en == 0.
REQ-021 prng_step SHALL be 1 in every CLEAR cycle when STRONG=1, and 1 in the DONE cycle regardless of STRONG.
REQ-022 DONE: fence_ack=1 for exactly one cycle; next state IDLE.
REQ-023 Latency: fence_req accepted at edge T -> fence_ack at cycle T+k+1, k = popcount(ALCFG) at T.
REQ-024 The requester SHALL drop fence_req in the cycle after fence_ack; if fence_req is still high in IDLE, it is a new fence.
REQ-025 cfg_wen=1 SHALL update ALCFG at any state; an in-flight sequence uses its pending snapshot only.
REQ-026 cfg_wen and fence acceptance on the same edge: the snapshot takes the old ALCFG, and the new value is visible next cycle.
REQ-027 fence_req deassertion during CLEAR or DONE SHALL NOT abort the sequence.
REQ-028 clr_en, fence_ack and prng_step SHALL be 0 in IDLE.

Reset
REQ-029 g_reset=1 SHALL asynchronously force state=IDLE, pending=0 and ALCFG=ALCFG_RESET_VALUE.
REQ-030 During reset, busy, fence_ack, prng_step, clr_en and clr_data SHALL be 0.
REQ-031 Reset mid-sequence SHALL abandon it with no fence_ack; the first fence after reset starts clean.

Structure
REQ-032 The shared frv_common package SHALL hold the FSM state encodings, the NRES default and the resource index constants.
REQ-033 The lowest-set-bit one-hot picker SHALL be a sub-module frv_leak_pick (in NRES, out NRES).
REQ-034 The block is fully synchronous apart from the reset, with no combinational path from fence_req to clr_en.

Verification
REQ-035 ALCFG=13'h0005, STRONG=1, fence_req -> clr_en=0x0001 then 0x0004 with clr_data=leak_prng, prng_step in 3 cycles, ack at T+3.
REQ-036 ALCFG=0, fence_req -> no clr_en; prng_step and fence_ack together at T+1.
REQ-037 STRONG=0, ALCFG=13'h1FFF -> 13 one-hot strobes in ascending order, clr_data=0, one prng_step at DONE, ack at T+14.
REQ-038 cfg_wen with 13'h0002 on the accept edge while ALCFG=13'h0008 -> only clr_en=0x0008; cfg_rdata=0x0002 afterwards.
REQ-039 Reset asserted in the 2nd CLEAR cycle of ALCFG=13'h0007 -> outputs 0 immediately, no ack, ALCFG=reset value.
REQ-040 fence_req held high across ack -> a second sequence starts from IDLE the cycle after DONE, using the current ALCFG.
